register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write, dual-read register file in the single-cycle datapath. It adds the following:
- N read ports and M write ports, with fixed write-port priority.
- Optional same-cycle write-to-read bypass.
- Optional hardwired zero register.
- A per-register busy scoreboard so multi-issue/pipelined datapaths can detect pending producers.
- Asynchronous clear of all state.

Parameters:
WordLen, 32, data word width in bits
WordCount, 32, number of registers (power of two, >= 2)
NumRead, 2, number of read ports (>= 1)
NumWrite, 2, number of write ports (>= 1)
ZeroReg, 1, 1 = register 0 hardwired to zero, never busy
Bypass, 1, 1 = reads see same-cycle write data
AddrLen, clog2(WordCount), derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
regWrite  input  NumWrite  per-port write enable
writeRegister  input  NumWrite*AddrLen  write addresses, port p at bits [p*AddrLen +: AddrLen]
writeData  input  NumWrite*WordLen  write data, port p at [p*WordLen +: WordLen]
readRegister  input  NumRead*AddrLen  read addresses, port r packed likewise
readData  output  NumRead*WordLen  read data, port r packed likewise
reserve  input  1  mark reserveRegister busy (producer issued)
reserveRegister  input  AddrLen  register to mark busy
readBusy  output  NumRead  busy flag for each read address

Behaviour:
- Reset (rst=1, asynchronous): every register cleared to 0 and every busy bit cleared. Writes and reserves are ignored while rst=1. readData therefore shows 0 and readBusy shows 0 for all ports, both during reset and after release, until written. Reset asserted mid-write: the write is lost and the register stays 0.
- Write, on the rising edge of clk:
  - Each port p with regWrite[p]=1 updates the register at writeRegister[p].
  - Several ports writing the same address in one cycle: the highest-index port wins.
  - ZeroReg=1: writes to address 0 are dropped.
- Read is combinational, with zero cycles latency from readRegister:
  - Bypass=0: readData[r] is the registered content.
  - Bypass=1: if any port p has regWrite[p]=1 and writeRegister[p] equals readRegister[r], readData[r] is writeData of the highest such p; otherwise it is the registered content.
  - ZeroReg=1: address 0 always reads 0, including when bypass applies.
- Scoreboard (busy[WordCount]), sampled on the rising edge:
  - A write to register a clears busy[a].
  - reserve=1 sets busy[reserveRegister].
  - reserve and a write to the same register in the same cycle: set wins, because a new producer supersedes the old one.
  - ZeroReg=1: busy[0] is held at 0.
- readBusy[r] is busy[readRegister[r]]. When Bypass=1, it is additionally masked to 0 if a same-cycle write to that address is in progress, so the forwarded data is valid.
- Address range: all addresses in 0..WordCount-1 are legal and there are no out-of-range cases.
- Reads of a never-written register return 0.

Decomposition:
- Shared package `regfile_pkg`: `bits` function (clog2), default WordLen/WordCount constants, and the packed-port slice helpers.
- One natural sub-module, `regfile_write_arbiter`. Given the regWrite/writeRegister vectors and a target address, it returns hit and winning data with highest-index priority.
- The arbiter is instanced once per read port for bypass and once per register for storage update.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle after writing reg5=0xA5A5A5A5 -> readData for reg5 = 0 immediately, and readBusy = 0.
2. Dual write: port0 writes reg3=0x11 and port1 writes reg7=0x22 in the same cycle -> next cycle, reg3 reads 0x11 and reg7 reads 0x22.
3. Collision: port0 writes reg4=0x33 and port1 writes reg4=0x44 in the same cycle -> reg4 reads 0x44 afterwards. With Bypass=1, readData shows 0x44 during the write cycle.
4. Zero register: write reg0=0xFFFFFFFF and reserve reg0 -> reg0 reads 0 and readBusy for reg0 = 0. With ZeroReg=0 in a second configuration -> reads 0xFFFFFFFF.
5. Bypass: Bypass=1, read reg9 while writing reg9=0xDEAD -> readData = 0xDEAD in the same cycle. With Bypass=0 -> old value in the same cycle, 0xDEAD the next cycle.
6. Scoreboard:
   - Reserve reg12 -> readBusy=1 from the next cycle.
   - Write reg12 -> readBusy=0 in the write cycle (Bypass=1) and in later cycles.
   - Simultaneous reserve and write of reg12 -> busy remains 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// It holds the address-width function and the index helper for packed port vectors.
package regfile_pkg;

    localparam int DefWordLen   = 32;
    localparam int DefWordCount = 32;

    // Ceiling log2, floored at one bit so a two-entry file still has an address bit.
    function automatic int bits(input int n);
        int w;
        w = 32'sd0;
        for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            w = w + 32'sd1;
        end
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // Low bit of the slice for a given port in a packed multi-port vector.
    function automatic int sliceLo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// Resolves all write ports against one target address.
// When several ports hit the target, the highest-index port supplies the data.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int WordLen  = DefWordLen,
    parameter int AddrLen  = 5,
    parameter int NumWrite = 2
) (
    input  logic [NumWrite-1:0]         regWrite,
    input  logic [NumWrite*AddrLen-1:0] writeRegister,
    input  logic [NumWrite*WordLen-1:0] writeData,
    input  logic [AddrLen-1:0]          target,
    output logic                        hit,
    output logic [WordLen-1:0]          data
);

    // Scan ports in ascending order so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int p = 0; p < NumWrite; p++) begin
            if (regWrite[p] && (writeRegister[sliceLo(p, AddrLen) +: AddrLen] == target)) begin
                hit  = 1'b1;
                data = writeData[sliceLo(p, WordLen) +: WordLen];
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: prioritised writes, optional bypass and zero register,
// and a per-register busy scoreboard for detecting pending producers.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int WordLen   = DefWordLen,
    parameter int WordCount = DefWordCount,
    parameter int NumRead   = 2,
    parameter int NumWrite  = 2,
    parameter bit ZeroReg   = 1'b1,
    parameter bit Bypass    = 1'b1,
    localparam int AddrLen  = bits(WordCount)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumWrite-1:0]         regWrite,
    input  logic [NumWrite*AddrLen-1:0] writeRegister,
    input  logic [NumWrite*WordLen-1:0] writeData,
    input  logic [NumRead*AddrLen-1:0]  readRegister,
    output logic [NumRead*WordLen-1:0]  readData,
    input  logic                        reserve,
    input  logic [AddrLen-1:0]          reserveRegister,
    output logic [NumRead-1:0]          readBusy
);

    logic [WordLen-1:0]   regs   [WordCount];
    logic [WordLen-1:0]   wrData [WordCount];
    logic [WordCount-1:0] wrHit;
    logic [WordCount-1:0] busy;

    for (genvar g = 0; g < WordCount; g++) begin : gStore
        regfile_write_arbiter #(
            .WordLen (WordLen),
            .AddrLen (AddrLen),
            .NumWrite(NumWrite)
        ) uArb (
            .regWrite     (regWrite),
            .writeRegister(writeRegister),
            .writeData    (writeData),
            .target       (AddrLen'(g)),
            .hit          (wrHit[g]),
            .data         (wrData[g])
        );
    end

    // Storage and scoreboard update; a reserve beats a same-cycle write because the new producer supersedes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WordCount; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < WordCount; i++) begin
                if (wrHit[i] && !(ZeroReg && (i == 32'sd0))) begin
                    regs[i] <= wrData[i];
                end else begin
                    regs[i] <= regs[i];
                end
                if (ZeroReg && (i == 32'sd0)) begin
                    busy[i] <= 1'b0;
                end else if (reserve && (reserveRegister == AddrLen'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wrHit[i]) begin
                    busy[i] <= 1'b0;
                end else begin
                    busy[i] <= busy[i];
                end
            end
        end
    end

    for (genvar r = 0; r < NumRead; r++) begin : gRead
        logic [AddrLen-1:0] addr;
        logic               bypHit;
        logic [WordLen-1:0] bypData;
        logic [WordLen-1:0] dataS;
        logic               busyS;

        assign addr = readRegister[r*AddrLen +: AddrLen];

        regfile_write_arbiter #(
            .WordLen (WordLen),
            .AddrLen (AddrLen),
            .NumWrite(NumWrite)
        ) uByp (
            .regWrite     (regWrite),
            .writeRegister(writeRegister),
            .writeData    (writeData),
            .target       (addr),
            .hit          (bypHit),
            .data         (bypData)
        );

        // Zero register dominates; a forwarded write also hides the busy flag since its data is already here.
        always_comb begin
            dataS = regs[addr];
            busyS = busy[addr];
            if (ZeroReg && (addr == '0)) begin
                dataS = '0;
                busyS = 1'b0;
            end else if (Bypass && bypHit) begin
                dataS = bypData;
                busyS = 1'b0;
            end else begin
                dataS = regs[addr];
                busyS = busy[addr];
            end
        end

        assign readData[r*WordLen +: WordLen] = dataS;
        assign readBusy[r]                    = busyS;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: two configurations (zero reg + bypass, and neither) against a
// behavioural array model, plus directed literal checks.
module tb_register_file_mp;

    localparam int WL = 32;
    localparam int WC = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AL = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    regWrite;
    logic [NW*AL-1:0] writeRegister;
    logic [NW*WL-1:0] writeData;
    logic [NR*AL-1:0] readRegister;
    logic [NR*WL-1:0] readDataA, readDataB;
    logic             reserve;
    logic [AL-1:0]    reserveRegister;
    logic [NR-1:0]    readBusyA, readBusyB;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model state, index 0 = config A (ZeroReg=1, Bypass=1), index 1 = config B (both off)
    logic [WL-1:0] memM  [2][WC];
    bit            busyM [2][WC];

    always #5 clk = ~clk;

    register_file_mp #(.WordLen(WL), .WordCount(WC), .NumRead(NR), .NumWrite(NW),
                       .ZeroReg(1'b1), .Bypass(1'b1)) dutA (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .readRegister(readRegister), .readData(readDataA),
        .reserve(reserve), .reserveRegister(reserveRegister), .readBusy(readBusyA));

    register_file_mp #(.WordLen(WL), .WordCount(WC), .NumRead(NR), .NumWrite(NW),
                       .ZeroReg(1'b0), .Bypass(1'b0)) dutB (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .readRegister(readRegister), .readData(readDataB),
        .reserve(reserve), .reserveRegister(reserveRegister), .readBusy(readBusyB));

    function automatic bit cfgOn(input int c);
        return (c == 0);
    endfunction

    function automatic logic [WL-1:0] expData(input int c, input int r);
        int a;
        logic [WL-1:0] v;
        a = int'(readRegister[r*AL +: AL]);
        v = memM[c][a];
        if (cfgOn(c) && a == 0) return '0;
        if (cfgOn(c)) begin
            for (int p = 0; p < NW; p++) begin
                if (regWrite[p] && int'(writeRegister[p*AL +: AL]) == a) v = writeData[p*WL +: WL];
            end
        end
        return v;
    endfunction

    function automatic bit expBusy(input int c, input int r);
        int a;
        a = int'(readRegister[r*AL +: AL]);
        if (cfgOn(c) && a == 0) return 1'b0;
        if (cfgOn(c)) begin
            for (int p = 0; p < NW; p++) begin
                if (regWrite[p] && int'(writeRegister[p*AL +: AL]) == a) return 1'b0;
            end
        end
        return busyM[c][a];
    endfunction

    function automatic logic [WL-1:0] dutData(input int c, input int r);
        return (c == 0) ? readDataA[r*WL +: WL] : readDataB[r*WL +: WL];
    endfunction

    function automatic bit dutBusy(input int c, input int r);
        return (c == 0) ? readBusyA[r] : readBusyB[r];
    endfunction

    // Model update: writes in ascending port order (last wins), then reserve overrides the clear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < WC; i++) begin
                    memM[c][i]  <= '0;
                    busyM[c][i] <= 1'b0;
                end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < NW; p++) begin
                    if (regWrite[p]) begin
                        if (!(cfgOn(c) && writeRegister[p*AL +: AL] == 5'd0))
                            memM[c][writeRegister[p*AL +: AL]] <= writeData[p*WL +: WL];
                        busyM[c][writeRegister[p*AL +: AL]] <= 1'b0;
                    end
                end
                if (reserve) busyM[c][reserveRegister] <= 1'b1;
                if (cfgOn(c)) busyM[c][0] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every read port of both configurations.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < NR; r++) begin
                    checks++;
                    if (dutData(c, r) !== expData(c, r)) begin
                        errors++;
                        $display("FAIL cfg%0d_rd%0d_data got %h expected %h", c, r, dutData(c, r), expData(c, r));
                    end
                    checks++;
                    if (dutBusy(c, r) !== expBusy(c, r)) begin
                        errors++;
                        $display("FAIL cfg%0d_rd%0d_busy got %0b expected %0b", c, r, dutBusy(c, r), expBusy(c, r));
                    end
                end
            end
        end
    end

    task automatic lit(input string name, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        regWrite        = '0;
        writeRegister   = '0;
        writeData       = '0;
        readRegister    = '0;
        reserve         = 1'b0;
        reserveRegister = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    task automatic chk();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [WL-1:0] d);
        regWrite[p]              = 1'b1;
        writeRegister[p*AL +: AL] = AL'(a);
        writeData[p*WL +: WL]     = d;
    endtask

    task automatic rd(input int r, input int a);
        readRegister[r*AL +: AL] = AL'(a);
    endtask

    task automatic rsv(input int a);
        reserve         = 1'b1;
        reserveRegister = AL'(a);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        checkEn = 1'b1;
        chk();
        lit("rst_data", readDataA[WL-1:0], 32'h0);
        step();

        // Reset mid-cycle after a write and a reserve
        wr(0, 5, 32'hA5A5_A5A5); rsv(5);
        step(); rd(0, 5); rd(1, 5);
        chk();
        lit("t1_data", dutData(0, 0), 32'hA5A5_A5A5);
        lit("t1_busy", {31'd0, readBusyA[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        lit("t1_rst_dataA", dutData(0, 0), 32'h0);
        lit("t1_rst_dataB", dutData(1, 1), 32'h0);
        lit("t1_rst_busy", {31'd0, readBusyA[0]}, 32'd0);

        // Dual write
        step(); wr(0, 3, 32'h11); wr(1, 7, 32'h22);
        step(); rd(0, 3); rd(1, 7);
        chk();
        lit("t2_r3", dutData(0, 0), 32'h11);
        lit("t2_r7", dutData(0, 1), 32'h22);
        lit("t2_r7B", dutData(1, 1), 32'h22);

        // Collision: port 1 wins
        step(); wr(0, 4, 32'h33); wr(1, 4, 32'h44); rd(0, 4);
        chk();
        lit("t3_bypA", dutData(0, 0), 32'h44);
        lit("t3_oldB", dutData(1, 0), 32'h0);
        step(); rd(0, 4);
        chk();
        lit("t3_after", dutData(1, 0), 32'h44);

        // Zero register
        step(); wr(0, 0, 32'hFFFF_FFFF); rsv(0); rd(0, 0);
        chk();
        lit("t4_bypZero", dutData(0, 0), 32'h0);
        step(); rd(0, 0);
        chk();
        lit("t4_zeroA", dutData(0, 0), 32'h0);
        lit("t4_busyA", {31'd0, readBusyA[0]}, 32'd0);
        lit("t4_dataB", dutData(1, 0), 32'hFFFF_FFFF);
        lit("t4_busyB", {31'd0, readBusyB[0]}, 32'd1);

        // Bypass
        step(); wr(1, 9, 32'hDEAD); rd(1, 9);
        chk();
        lit("t5_bypA", dutData(0, 1), 32'hDEAD);
        lit("t5_oldB", dutData(1, 1), 32'h0);
        step(); rd(1, 9);
        chk();
        lit("t5_nextB", dutData(1, 1), 32'hDEAD);

        // Scoreboard
        step(); rsv(12); rd(0, 12);
        chk();
        lit("t6_notyet", {31'd0, readBusyA[0]}, 32'd0);
        step(); rd(0, 12);
        chk();
        lit("t6_busy", {31'd0, readBusyA[0]}, 32'd1);
        step(); rd(0, 12); wr(1, 12, 32'h77);
        chk();
        lit("t6_wcycA", {31'd0, readBusyA[0]}, 32'd0);
        lit("t6_wcycB", {31'd0, readBusyB[0]}, 32'd1);
        step(); rd(0, 12);
        chk();
        lit("t6_clrB", {31'd0, readBusyB[0]}, 32'd0);
        step(); rsv(12); wr(0, 12, 32'h55);
        step(); rd(0, 12);
        chk();
        lit("t6_setwinsA", {31'd0, readBusyA[0]}, 32'd1);
        lit("t6_setwinsB", {31'd0, readBusyB[0]}, 32'd1);

        // Randomized traffic, addresses biased low to force collisions and bypass hits
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, 15), $urandom);
            end
            for (int r = 0; r < NR; r++) rd(r, $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rsv($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
        end

        step();
        chk();
        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
